mem_exc_unit: RTL and testbench
===============================

# mem_exc_unit

Memory-stage exception unit for the pipelined MIPS core, sitting between the M-stage datapath and CP0. It classifies load/store addresses against a parametrised data-memory range and N device windows, merges the result with the exception code carried from E, and registers code and branch-delay flag into W. The first exception is captured into an ack-handshaked request (code, EPC, BadVAddr, BD) that stays held until CP0 accepts it.

## Interface
Parameters:
- DM_TOP, 32'h0000_2fff, highest valid data-memory byte address (DM spans 0..DM_TOP)
- NDEV, 2, number of device windows
- DEV_BASE, {32'h7f10, 32'h7f00}, packed NDEV×32 window base addresses; window i is bits [32i+31:32i]
- DEV_RSPAN, 12, readable bytes per window
- DEV_WSPAN, 8, writable bytes per window (≤ DEV_RSPAN)
- SUBWORD_DEV, 0, 1 = byte/half accesses to device windows permitted

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  M→W advance (0 = stall; W registers hold)
- flush  in  1  clear the W registers and abort a not-yet-captured exception
- valid_m  in  1  M stage holds a real instruction
- instr_m  in  32  M-stage instruction
- ao_m  in  32  effective address
- pc_m  in  32  M-stage PC
- exccode_e  in  5  code carried from E; 0 = none
- bd_e  in  1  M instruction is in a branch-delay slot
- exc_ack  in  1  CP0 accepts the pending request
- exccode_w  out  5  registered final code
- bd_w  out  1  registered BD flag
- exc_req  out  1  exception request pending
- exc_code  out  5  captured code
- exc_epc  out  32  captured EPC
- exc_badvaddr  out  32  captured faulting address (0 if not an address error)
- exc_bd  out  1  captured BD flag

## Operation
- Opcode decode on instr_m[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24 are loads; sw 0x2b, sh 0x29, sb 0x28 are stores. Any other opcode is a non-memory op.
- Alignment: word accesses need ao_m[1:0]=0; half accesses need ao_m[0]=0.
- Range: 0 ≤ ao_m ≤ DM_TOP is legal for any size. Otherwise the access is legal only if it hits some window i:
  - load: DEV_BASE_i ≤ ao_m < DEV_BASE_i+DEV_RSPAN
  - store: the same test with DEV_WSPAN
  - subword access: also requires SUBWORD_DEV=1
- All address comparisons are 32-bit unsigned; window ends are computed in 33 bits, so there is no wrap at 0xffff_ffff.
- A failed check gives addr_code: AdEL=4 for loads, AdES=5 for stores. Non-memory ops never produce addr_code.
- Merge priority:
  - exccode_e=12 (Ov) on a load/store becomes AdEL/AdES.
  - Otherwise any nonzero exccode_e wins.
  - Otherwise the result is addr_code, or 0.
- The code is forced to 0 when valid_m=0.
- EPC = pc_m−4 if bd_e, else pc_m.
- BadVAddr = ao_m when the final code is 4 or 5, else 0.
- Capture FSM:
  - IDLE→PEND when en & ~flush & valid_m & final≠0. On that edge it latches exc_code, exc_epc, exc_badvaddr and exc_bd.
  - PEND→IDLE on exc_ack.
  - In PEND, new detections are ignored and the captured fields are frozen.
  - flush does not abort PEND.
- exc_req = (state==PEND).

## Timing
- Reset: every output 0, FSM in IDLE.
- exccode_w and bd_w take the merged code and bd_e one cycle after an edge with en=1.
- flush=1 clears exccode_w and bd_w to 0 on the next edge. flush overrides en.
- exc_req rises on the edge after detection (1-cycle latency). It falls on the edge after exc_ack is sampled high.
- exc_ack while IDLE is ignored.
- Simultaneous exc_ack and a new detection in PEND: the FSM returns to IDLE and the new detection is dropped.
- Reset asserted mid-PEND clears exc_req immediately (asynchronous).

## Test plan
- Misaligned lw: ao_m=0x0000_0102, pc_m=0x3010, bd_e=0 → next cycle exccode_w=4, exc_req=1, exc_epc=0x3010, exc_badvaddr=0x102.
- Device window: sw to 0x7f08 → exccode_w=5. sw to 0x7f04 → exccode_w=0. lw from 0x7f18 → exccode_w=0.
- sb to 0x7f00:
  - SUBWORD_DEV=0 → exccode_w=5.
  - SUBWORD_DEV=1 → exccode_w=0.
  - NDEV=3 with a third base 0x7f20: lw from 0x7f24 → exccode_w=0.
- Priority:
  - lw at 0x2ffd with exccode_e=10 → exccode_w=10.
  - lw with exccode_e=12 → exccode_w=4.
  - Non-memory op with exccode_e=0 and ao_m=0xffff_ffff → exccode_w=0, no request.
- Handshake: hold exc_ack=0 for 5 cycles while injecting a second fault → exc_req stays 1 and the fields keep the first fault. exc_ack=1 → exc_req=0 on the next edge.
- Control events:
  - bd_e=1, pc_m=0x3020 → exc_epc=0x301c.
  - en=0 → exccode_w holds.
  - flush together with a fault → exccode_w=0, no capture.
  - reset low mid-PEND → all outputs 0 at once.

Source files
------------

// File: rtl/mem_exc_unit.sv
// Memory-stage exception unit: classifies load/store addresses, merges with the E-stage code,
// registers code/BD into W and holds the first exception as an ack-handshaked request to CP0.
module mem_exc_unit #(
    parameter logic [31:0]        DM_TOP      = 32'h0000_2fff,
    parameter int unsigned        NDEV        = 2,
    parameter logic [NDEV*32-1:0] DEV_BASE    = {32'h0000_7f10, 32'h0000_7f00},
    parameter int unsigned        DEV_RSPAN   = 12,
    parameter int unsigned        DEV_WSPAN   = 8,
    parameter bit                 SUBWORD_DEV = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        valid_m,
    input  logic [31:0] instr_m,
    input  logic [31:0] ao_m,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exccode_e,
    input  logic        bd_e,
    input  logic        exc_ack,
    output logic [4:0]  exccode_w,
    output logic        bd_w,
    output logic        exc_req,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    output logic        exc_bd
);

    localparam int unsigned CODE_W = 5;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

    typedef enum logic {IDLE, PEND} state_t;

    state_t            state;
    logic              is_load, is_store, is_word, is_half, mem_op;
    logic              misalign, dev_hit, legal;
    logic [31:0]       win_base;
    logic [32:0]       win_lim;
    logic [CODE_W-1:0] addr_code, final_code;
    logic [31:0]       epc, badvaddr;
    logic              capture;

    // Decode, alignment and range classification
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_word  = 1'b0;
        is_half  = 1'b0;
        case (instr_m[31:26])
            OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LB, OP_LBU: begin is_load  = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SB:         begin is_store = 1'b1; end
            default:       ;
        endcase
        mem_op   = is_load | is_store;
        misalign = (is_word & (ao_m[1:0] != 2'b00)) | (is_half & ao_m[0]);

        // Window ends in 33 bits so a window near the top of memory cannot wrap
        dev_hit  = 1'b0;
        win_base = '0;
        win_lim  = '0;
        for (int i = 0; i < int'(NDEV); i++) begin
            win_base = DEV_BASE[32*i +: 32];
            win_lim  = {1'b0, win_base} + (is_store ? 33'(DEV_WSPAN) : 33'(DEV_RSPAN));
            if ((ao_m >= win_base) && ({1'b0, ao_m} < win_lim)) begin
                dev_hit = 1'b1;
            end
        end
        legal = (ao_m <= DM_TOP) | (dev_hit & (is_word | SUBWORD_DEV));

        addr_code = '0;
        if (mem_op && (misalign || !legal)) begin
            addr_code = is_load ? EXC_ADEL : EXC_ADES;
        end
    end

    // Merge with the carried code; Ov on a memory op is really an address error
    always_comb begin
        final_code = addr_code;
        if (mem_op && exccode_e == EXC_OV) begin
            final_code = is_load ? EXC_ADEL : EXC_ADES;
        end else if (exccode_e != '0) begin
            final_code = exccode_e;
        end
        if (!valid_m) begin
            final_code = '0;
        end
        epc      = bd_e ? (pc_m - 32'd4) : pc_m;
        badvaddr = ((final_code == EXC_ADEL) || (final_code == EXC_ADES)) ? ao_m : 32'd0;
        capture  = en & ~flush & valid_m & (final_code != '0);
    end

    // M->W pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exccode_w <= '0;
            bd_w      <= 1'b0;
        end else if (flush) begin
            exccode_w <= '0;
            bd_w      <= 1'b0;
        end else if (en) begin
            exccode_w <= final_code;
            bd_w      <= bd_e;
        end
    end

    // Capture FSM: first exception held until CP0 acknowledges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            exc_req      <= 1'b0;
            exc_code     <= '0;
            exc_epc      <= '0;
            exc_badvaddr <= '0;
            exc_bd       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state        <= PEND;
                        exc_req      <= 1'b1;
                        exc_code     <= final_code;
                        exc_epc      <= epc;
                        exc_badvaddr <= badvaddr;
                        exc_bd       <= bd_e;
                    end
                end
                PEND: begin
                    if (exc_ack) begin
                        state   <= IDLE;
                        exc_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    exc_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_exc_unit.sv
// Scoreboard bench for mem_exc_unit: default instance plus a 3-window, subword-enabled instance.
module tb_mem_exc_unit;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_RT = 6'h00;

    typedef struct {
        string       name;
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic        bdw;
        logic        req;
        logic [4:0]  ecode;
        logic [31:0] epc;
        logic [31:0] bva;
        logic        ebd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1, flush = 1'b0, valid_m = 1'b1, bd_e = 1'b0, exc_ack = 1'b0;
    logic [31:0] instr_m = '0, ao_m = '0, pc_m = '0;
    logic [4:0]  exccode_e = '0;

    logic [4:0]  exccode_w0, exc_code0, exccode_w1, exc_code1;
    logic        bd_w0, exc_req0, exc_bd0, bd_w1, exc_req1, exc_bd1;
    logic [31:0] exc_epc0, exc_badvaddr0, exc_epc1, exc_badvaddr1;

    exp_t exp_q[$];
    bit   chk_now = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_exc_unit u_dut0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_m(valid_m),
        .instr_m(instr_m), .ao_m(ao_m), .pc_m(pc_m), .exccode_e(exccode_e), .bd_e(bd_e),
        .exc_ack(exc_ack), .exccode_w(exccode_w0), .bd_w(bd_w0), .exc_req(exc_req0),
        .exc_code(exc_code0), .exc_epc(exc_epc0), .exc_badvaddr(exc_badvaddr0), .exc_bd(exc_bd0)
    );

    mem_exc_unit #(
        .NDEV(3),
        .DEV_BASE({32'h0000_7f20, 32'h0000_7f10, 32'h0000_7f00}),
        .SUBWORD_DEV(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_m(valid_m),
        .instr_m(instr_m), .ao_m(ao_m), .pc_m(pc_m), .exccode_e(exccode_e), .bd_e(bd_e),
        .exc_ack(exc_ack), .exccode_w(exccode_w1), .bd_w(bd_w1), .exc_req(exc_req1),
        .exc_code(exc_code1), .exc_epc(exc_epc1), .exc_badvaddr(exc_badvaddr1), .exc_bd(exc_bd1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [4:0] c0, input logic [4:0] c1,
                                input logic bdw, input logic req, input logic [4:0] ecode,
                                input logic [31:0] epc, input logic [31:0] bva, input logic ebd);
        exp_t x;
        x.name = nm; x.c0 = c0; x.c1 = c1; x.bdw = bdw; x.req = req;
        x.ecode = ecode; x.epc = epc; x.bva = bva; x.ebd = ebd;
        return x;
    endfunction

    // Drive one vector at the falling edge and queue its expected post-edge response
    task automatic vec(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] pc,
                       input logic [4:0] ee, input logic bd, input logic v, input logic e,
                       input logic f, input logic ack, input exp_t x);
        @(negedge clk);
        instr_m = {op, 26'h0};
        ao_m = ao; pc_m = pc; exccode_e = ee; bd_e = bd;
        valid_m = v; en = e; flush = f; exc_ack = ack;
        exp_q.push_back(x);
        chk_now = 1'b1;
    endtask

    // Monitor: compares the queued expectation against both DUTs after each checked edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (chk_now) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    chk({x.name, ".code0"}, 32'(exccode_w0), 32'(x.c0));
                    chk({x.name, ".code1"}, 32'(exccode_w1), 32'(x.c1));
                    chk({x.name, ".bd_w"},  32'(bd_w0),      32'(x.bdw));
                    chk({x.name, ".req"},   32'(exc_req0),   32'(x.req));
                    if (x.req) begin
                        chk({x.name, ".exc_code"}, 32'(exc_code0), 32'(x.ecode));
                        chk({x.name, ".epc"},      exc_epc0,       x.epc);
                        chk({x.name, ".badva"},    exc_badvaddr0,  x.bva);
                        chk({x.name, ".exc_bd"},   32'(exc_bd0),   32'(x.ebd));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst.code", 32'(exccode_w0), 32'd0);
        chk("rst.req",  32'(exc_req0),   32'd0);
        chk("rst.epc",  exc_epc0,        32'd0);
        chk("rst.bva",  exc_badvaddr0,   32'd0);
        chk("rst.bd",   32'(bd_w0),      32'd0);
        @(negedge clk);
        reset = 1'b1;

        // First fault captured; then five cycles of further faults with ack low
        vec(OP_LW, 32'h0000_0102, 32'h3010, 5'd0, 0, 1, 1, 0, 0, mk("lw_misalign", 4, 4, 0, 1, 4, 32'h3010, 32'h102, 0));
        vec(OP_SW, 32'h0000_7f08, 32'h3014, 5'd0, 0, 1, 1, 0, 0, mk("sw_dev_wend", 5, 5, 0, 1, 4, 32'h3010, 32'h102, 0));
        vec(OP_SW, 32'h0000_7f04, 32'h3018, 5'd0, 0, 1, 1, 0, 0, mk("sw_dev_ok",   0, 0, 0, 1, 4, 32'h3010, 32'h102, 0));
        vec(OP_LW, 32'h0000_7f18, 32'h301c, 5'd0, 0, 1, 1, 0, 0, mk("lw_dev1_ok",  0, 0, 0, 1, 4, 32'h3010, 32'h102, 0));
        vec(OP_SB, 32'h0000_7f00, 32'h3020, 5'd0, 0, 1, 1, 0, 0, mk("sb_dev",      5, 0, 0, 1, 4, 32'h3010, 32'h102, 0));
        vec(OP_LW, 32'h0000_7f24, 32'h3024, 5'd0, 0, 1, 1, 0, 0, mk("lw_dev2",     4, 0, 0, 1, 4, 32'h3010, 32'h102, 0));
        // Ack with a simultaneous new detection: request drops, detection lost
        vec(OP_LW, 32'h0000_2ffd, 32'h3028, 5'd10, 0, 1, 1, 0, 1, mk("ack_drop",   10, 10, 0, 0, 0, 0, 0, 0));
        vec(OP_LW, 32'h0000_0100, 32'h3020, 5'd12, 1, 1, 1, 0, 0, mk("ov_load_bd",  4, 4, 1, 1, 4, 32'h301c, 32'h100, 1));
        vec(OP_RT, 32'hffff_ffff, 32'h3030, 5'd0, 0, 1, 1, 0, 1, mk("ack",          0, 0, 0, 0, 0, 0, 0, 0));
        vec(OP_RT, 32'hffff_ffff, 32'h3034, 5'd0, 0, 1, 1, 0, 0, mk("nonmem_hi",    0, 0, 0, 0, 0, 0, 0, 0));
        vec(OP_RT, 32'hffff_ffff, 32'h3038, 5'd0, 0, 1, 1, 0, 1, mk("ack_idle",     0, 0, 0, 0, 0, 0, 0, 0));
        vec(OP_LW, 32'h0000_0001, 32'h303c, 5'd0, 1, 1, 1, 1, 0, mk("flush_fault",  0, 0, 0, 0, 0, 0, 0, 0));
        vec(OP_SW, 32'h0000_3000, 32'h3050, 5'd0, 0, 1, 1, 0, 0, mk("sw_above_dm",  5, 5, 0, 1, 5, 32'h3050, 32'h3000, 0));
        vec(OP_LW, 32'h0000_0003, 32'h3054, 5'd0, 1, 1, 0, 0, 0, mk("en_hold",      5, 5, 0, 1, 5, 32'h3050, 32'h3000, 0));
        vec(OP_RT, 32'h0000_0000, 32'h3058, 5'd10, 0, 0, 1, 0, 0, mk("invalid",     0, 0, 0, 1, 5, 32'h3050, 32'h3000, 0));

        // Asynchronous reset while pending
        @(negedge clk);
        chk_now = 1'b0;
        valid_m = 1'b0; exc_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst.req0",  32'(exc_req0),   32'd0);
        chk("arst.req1",  32'(exc_req1),   32'd0);
        chk("arst.code",  32'(exc_code0),  32'd0);
        chk("arst.epc",   exc_epc0,        32'd0);
        chk("arst.bva",   exc_badvaddr0,   32'd0);
        chk("arst.codew", 32'(exccode_w0), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        vec(OP_RT, 32'h0000_0040, 32'h3060, 5'd12, 0, 1, 1, 0, 0, mk("ov_nonmem", 12, 12, 0, 1, 12, 32'h3060, 32'h0, 0));
        vec(OP_RT, 32'h0000_0040, 32'h3064, 5'd0, 0, 1, 1, 0, 1, mk("ack_final",    0, 0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        chk_now = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
